// File: rtl/if_imem_resp.sv
// rtl/if_imem_resp.sv - instruction-memory responder with wait states, error flagging and a preload port
module if_imem_resp #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_pc_ce_i,
    input  logic [31:0]       if_pc_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [31:0]       ld_data_i,
    output logic              imem_busy_o,
    output logic              imem_valid_o,
    output logic [31:0]       imem_inst_o,
    output logic              imem_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t            state;
    state_t            state_n;
    logic [3:0]        cnt;
    logic [3:0]        cnt_n;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_n;
    logic              err_q;
    logic              err_n;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rdata;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] req_idx;
    logic              req_err;

    assign req_idx = if_pc_i[ADDR_W+1:2];
    // Any address bit above the word index means the fetch falls outside the array.
    assign req_err = (if_pc_i[1:0] != 2'b00) || ((if_pc_i >> (ADDR_W + 2)) != 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            idx   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            err_q <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        err_n   = err_q;
        rd_en   = 1'b0;
        rd_addr = idx;
        case (state)
            S_IDLE, S_RESP: begin
                if (if_pc_ce_i) begin
                    idx_n = req_idx;
                    err_n = req_err;
                    if (req_err) begin
                        state_n = S_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        state_n = S_RESP;
                        rd_en   = 1'b1;
                        rd_addr = req_idx;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = WAIT_INIT;
                    end
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    rd_en   = 1'b1;
                    state_n = S_RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Read-first array with no reset: a load and read of the same word on one edge return old data.
    always_ff @(posedge clk) begin
        if (ld_we_i) begin
            mem[ld_addr_i] <= ld_data_i;
        end
        if (rd_en) begin
            rdata <= mem[rd_addr];
        end
    end

    always_comb begin
        imem_busy_o  = (state == S_WAIT);
        imem_valid_o = (state == S_RESP);
        imem_inst_o  = (imem_valid_o && !err_q) ? rdata : 32'd0;
        imem_err_o   = imem_valid_o && err_q;
    end

endmodule

// File: tb/tb_if_imem_resp.sv
// tb/tb_if_imem_resp.sv - vector table plus scoreboarded sequences for if_imem_resp
module tb_if_imem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic        ld_we;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic        busy  [3];
    logic        valid [3];
    logic [31:0] inst  [3];
    logic        err   [3];

    always #5 clk = ~clk;

    // Instance 0: two wait states, instance 1: none, instance 2: three.
    if_imem_resp #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .if_pc_ce_i(ce), .if_pc_i(pc),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .imem_busy_o(busy[0]), .imem_valid_o(valid[0]), .imem_inst_o(inst[0]), .imem_err_o(err[0]));
    if_imem_resp #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .if_pc_ce_i(ce), .if_pc_i(pc),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .imem_busy_o(busy[1]), .imem_valid_o(valid[1]), .imem_inst_o(inst[1]), .imem_err_o(err[1]));
    if_imem_resp #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .if_pc_ce_i(ce), .if_pc_i(pc),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .imem_busy_o(busy[2]), .imem_valid_o(valid[2]), .imem_inst_o(inst[2]), .imem_err_o(err[2]));

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        int          sel;
        logic [31:0] addr;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    exp_t        q[$];
    vec_t        vecs[10];
    logic [31:0] model [1024];
    int          lat[3] = '{3, 1, 4};
    int          sel = 0;
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid strobe of the selected instance must match the next expected response.
    always @(negedge clk) begin
        if (!rst && valid[sel]) begin
            exp_t e;
            total_cnt++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_valid dut%0d cyc=%0d: got inst=%h err=%b, required no response",
                         sel, cyc, inst[sel], err[sel]);
            end else begin
                e = q.pop_front();
                if (inst[sel] === e.inst && err[sel] === e.err && cyc == e.cyc)
                    pass_cnt++;
                else
                    $display("FAIL resp dut%0d: got inst=%h err=%b cyc=%0d, required inst=%h err=%b cyc=%0d",
                             sel, inst[sel], err[sel], cyc, e.inst, e.err, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", nm, got, want);
    endtask

    task automatic push(input logic [31:0] i, input logic e, input int c);
        exp_t x;
        x.inst = i;
        x.err  = e;
        x.cyc  = c;
        q.push_back(x);
    endtask

    task automatic wait_empty(input string nm);
        for (int i = 0; i < 30 && q.size() != 0; i++) tick();
        tick();
        chk({nm, "_drained"}, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic load(input int a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = 10'(a); ld_data = d;
        tick();
        ld_we = 1'b0;
        model[a] = d;
    endtask

    task automatic select(input int s);
        rst = 1'b1;
        tick();
        sel = s;
        rst = 1'b0;
    endtask

    task automatic do_req(input string nm, input logic [31:0] addr, input logic [31:0] ei, input logic ee);
        int n;
        n = 0;
        while (busy[sel] && n < 20) begin tick(); n++; end
        ce = 1'b1; pc = addr;
        push(ei, ee, cyc + (ee ? 1 : lat[sel]));
        tick();
        ce = 1'b0;
        wait_empty(nm);
    endtask

    initial begin
        int k;
        vecs[0] = '{0, 32'h0000_000C, 32'hA500_0003, 1'b0};
        vecs[1] = '{0, 32'h0000_0006, 32'h0,         1'b1};
        vecs[2] = '{0, 32'h0000_1000, 32'h0,         1'b1};
        vecs[3] = '{0, 32'h0000_0FFC, 32'h1234_5678, 1'b0};
        vecs[4] = '{1, 32'h0000_0008, 32'hA500_0002, 1'b0};
        vecs[5] = '{1, 32'h0000_000D, 32'h0,         1'b1};
        vecs[6] = '{1, 32'h0000_0FFC, 32'h1234_5678, 1'b0};
        vecs[7] = '{2, 32'h0000_0004, 32'hA500_0001, 1'b0};
        vecs[8] = '{2, 32'h8000_0000, 32'h0,         1'b1};
        vecs[9] = '{2, 32'h0000_002C, 32'hA500_000B, 1'b0};

        rst = 1'b1; ce = 1'b0; pc = 32'd0; ld_we = 1'b0; ld_addr = 10'd0; ld_data = 32'd0;
        tick();
        for (int i = 0; i < 16; i++) load(i, 32'hA500_0000 + 32'(i));
        load(5, 32'h2402_0005);
        load(1023, 32'h1234_5678);

        // Reset held three cycles with a request pending: it must be ignored.
        sel = 0;
        ce = 1'b1; pc = 32'h14;
        repeat (3) tick();
        rst = 1'b0; ce = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_busy%0d", d),  32'(busy[d]),  32'd0);
            chk($sformatf("rst_valid%0d", d), 32'(valid[d]), 32'd0);
            chk($sformatf("rst_inst%0d", d),  inst[d],       32'd0);
            chk($sformatf("rst_err%0d", d),   32'(err[d]),   32'd0);
        end
        k = cyc;
        ce = 1'b1; pc = 32'h14;
        push(32'h2402_0005, 1'b0, k + 3);
        tick();
        ce = 1'b0;
        chk("w2_busy_n1", 32'(busy[0]), 32'd1);
        tick();
        chk("w2_busy_n2", 32'(busy[0]), 32'd1);
        tick();
        chk("w2_busy_n3", 32'(busy[0]), 32'd0);
        wait_empty("first_fetch");

        for (int v = 0; v < 10; v++) begin
            if (v == 0 || vecs[v].sel != vecs[v-1].sel) select(vecs[v].sel);
            do_req($sformatf("vec%0d", v), vecs[v].addr, vecs[v].inst, vecs[v].err);
        end

        // Zero-wait streaming, one request per cycle.
        select(1);
        for (int i = 0; i < 4; i++) begin
            ce = 1'b1; pc = 32'(i * 4);
            push(model[i], 1'b0, cyc + 1);
            chk($sformatf("stream_busy%0d", i), 32'(busy[1]), 32'd0);
            tick();
        end
        ce = 1'b0;
        chk("stream_busy_end", 32'(busy[1]), 32'd0);
        wait_empty("stream");

        // Errored request accepted while the previous response is being driven.
        select(0);
        k = cyc;
        ce = 1'b1; pc = 32'h0;
        push(model[0], 1'b0, k + 3);
        tick();
        ce = 1'b0;
        tick();
        tick();
        ce = 1'b1; pc = 32'h6;
        push(32'd0, 1'b1, k + 4);
        tick();
        ce = 1'b0;
        wait_empty("err_in_resp");

        // Request during WAIT is dropped; only word 2 returns.
        select(2);
        k = cyc;
        ce = 1'b1; pc = 32'h8;
        push(model[2], 1'b0, k + 4);
        tick();
        chk("ign_busy", 32'(busy[2]), 32'd1);
        pc = 32'hC;
        tick();
        ce = 1'b0;
        wait_empty("ignored");
        repeat (6) tick();

        // Load before the read edge is visible; load at the read edge is not.
        select(0);
        k = cyc;
        ce = 1'b1; pc = 32'h10;
        push(32'hDEAD_BEEF, 1'b0, k + 3);
        tick();
        ce = 1'b0;
        load(4, 32'hDEAD_BEEF);
        wait_empty("load_early");
        load(4, 32'h5555_AAAA);
        k = cyc;
        ce = 1'b1; pc = 32'h10;
        push(32'h5555_AAAA, 1'b0, k + 3);
        tick();
        ce = 1'b0;
        tick();
        load(4, 32'hDEAD_BEEF);
        wait_empty("load_at_read");
        do_req("load_after", 32'h10, 32'hDEAD_BEEF, 1'b0);

        // Reset two cycles after accept cancels the response.
        select(2);
        ce = 1'b1; pc = 32'h4;
        tick();
        ce = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy",  32'(busy[2]),  32'd0);
        chk("mid_rst_valid", 32'(valid[2]), 32'd0);
        chk("mid_rst_inst",  inst[2],       32'd0);
        chk("mid_rst_err",   32'(err[2]),   32'd0);
        repeat (8) tick();
        do_req("mem_persist", 32'h4, model[1], 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
